// File: rtl/fpu_addsub_param.sv
// fpu_addsub_param: multi-cycle {sign, exp, man} add/subtract with RNE rounding.
// Latency: done_out pulses 6 clocks after start_in is sampled; one op per 6 clocks.
// Backpressure: none; start_in is ignored while busy, result held until next done_out.
module fpu_addsub_param #(
  parameter int EXP_W = 10,
  parameter int MAN_W = 21,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clock_100KHz,
  input  logic         reset,
  input  logic         start_in,
  input  logic         op_sel_in,
  input  logic [W-1:0] op_A_in,
  input  logic [W-1:0] op_B_in,
  output logic         busy_out,
  output logic         done_out,
  output logic [3:0]   status_out,
  output logic [W-1:0] data_out
);

  // Working significand: {hidden, man, G, R, S}; exponent is signed with headroom.
  localparam int SW  = MAN_W + 4;
  localparam int XW  = EXP_W + 2;
  localparam int LZW = $clog2(SW + 1);
  localparam logic [EXP_W-1:0] D_MAX   = EXP_W'(MAN_W + 3);
  localparam logic [XW-1:0]    EXP_OVF = XW'((1 << EXP_W) - 1);
  localparam logic [XW-1:0]    XONE    = XW'(1);
  localparam logic [XW-1:0]    XZERO   = '0;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ALIGN     = 3'd1,
    S_OPERATE   = 3'd2,
    S_NORMALIZE = 3'd3,
    S_ROUND     = 3'd4,
    S_PACK      = 3'd5
  } state_t;

  state_t r_state, w_state_nxt;

  // Captured operands
  logic             r_sign_a, r_sign_b;
  logic [EXP_W-1:0] r_exp_a, r_exp_b;
  logic [MAN_W:0]   r_man_a, r_man_b;
  // Aligned operands, larger exponent in the "hi" slot
  logic             r_sign_hi, r_sign_lo;
  logic [SW-1:0]    r_ext_hi, r_ext_lo;
  logic [XW-1:0]    r_exp;
  // Raw sum/difference, normalised and rounded values
  logic [SW:0]      r_sum;
  logic             r_sign;
  logic [SW-1:0]    r_norm;
  logic [MAN_W:0]   r_mant;
  logic             r_inexact;

  // Output registers
  logic             r_busy, r_done;
  logic [3:0]       r_status;
  logic [W-1:0]     r_data;

  // Operand decode at capture: a zero exponent field means the value zero.
  logic [EXP_W-1:0] w_exp_a_in, w_exp_b_in;
  logic [MAN_W:0]   w_man_a_in, w_man_b_in;
  assign w_exp_a_in = op_A_in[W-2:MAN_W];
  assign w_exp_b_in = op_B_in[W-2:MAN_W];
  assign w_man_a_in = (w_exp_a_in == '0) ? '0 : {1'b1, op_A_in[MAN_W-1:0]};
  assign w_man_b_in = (w_exp_b_in == '0) ? '0 : {1'b1, op_B_in[MAN_W-1:0]};

  // Alignment: the smaller-exponent operand is shifted right, lost bits fold into S.
  logic             w_swap, w_lo_sticky;
  logic [EXP_W-1:0] w_exp_hi, w_exp_lo, w_d;
  logic [MAN_W:0]   w_man_hi, w_man_lo;
  logic [SW-1:0]    w_lo_ext, w_lo_shr, w_lo_aligned;
  assign w_swap       = r_exp_b > r_exp_a;
  assign w_exp_hi     = w_swap ? r_exp_b : r_exp_a;
  assign w_exp_lo     = w_swap ? r_exp_a : r_exp_b;
  assign w_man_hi     = w_swap ? r_man_b : r_man_a;
  assign w_man_lo     = w_swap ? r_man_a : r_man_b;
  assign w_d          = w_exp_hi - w_exp_lo;
  assign w_lo_ext     = {w_man_lo, 3'b000};
  assign w_lo_shr     = w_lo_ext >> w_d;
  assign w_lo_sticky  = (w_lo_shr << w_d) != w_lo_ext;
  assign w_lo_aligned = (w_d > D_MAX) ? {{(SW-1){1'b0}}, |w_man_lo}
                                      : {w_lo_shr[SW-1:1], w_lo_shr[0] | w_lo_sticky};

  // Magnitude add or subtract; an exact cancellation yields +0.
  logic [SW:0] w_sum;
  logic        w_sign;
  always_comb begin
    w_sum  = '0;
    w_sign = r_sign_hi;
    if (r_sign_hi == r_sign_lo) begin
      w_sum = {1'b0, r_ext_hi} + {1'b0, r_ext_lo};
    end else if (r_ext_hi > r_ext_lo) begin
      w_sum = {1'b0, r_ext_hi} - {1'b0, r_ext_lo};
    end else if (r_ext_hi < r_ext_lo) begin
      w_sum  = {1'b0, r_ext_lo} - {1'b0, r_ext_hi};
      w_sign = r_sign_lo;
    end else begin
      w_sign = 1'b0;
    end
  end

  function automatic logic [LZW-1:0] lzc(input logic [SW-1:0] v);
    lzc = LZW'(SW);
    for (int i = 0; i < SW; i++) begin
      if (v[i]) lzc = LZW'(SW - 1 - i);
    end
  endfunction

  // Normalisation: carry-out shifts right once, otherwise shift left by the lzc.
  logic [LZW-1:0] w_lzc;
  logic [SW-1:0]  w_norm;
  logic [XW-1:0]  w_norm_exp;
  assign w_lzc = lzc(r_sum[SW-1:0]);
  always_comb begin
    w_norm     = r_sum[SW-1:0] << w_lzc;
    w_norm_exp = r_exp - XW'(w_lzc);
    if (r_sum[SW]) begin
      w_norm     = {r_sum[SW:2], r_sum[1] | r_sum[0]};
      w_norm_exp = r_exp + XONE;
    end
  end

  // Round to nearest even on {LSB, G, R, S} = r_norm[3:0].
  logic             w_inc;
  logic [MAN_W+1:0] w_rnd;
  assign w_inc = r_norm[2] & (r_norm[1] | r_norm[0] | r_norm[3]);
  assign w_rnd = {1'b0, r_norm[SW-1:3]} + {{(MAN_W+1){1'b0}}, w_inc};

  // Final packing with status priority OVERFLOW > UNDERFLOW > INEXACT > EXACT.
  logic [W-1:0] w_pack_data;
  logic [3:0]   w_pack_status;
  always_comb begin
    w_pack_data   = {r_sign, r_exp[EXP_W-1:0], r_mant[MAN_W-1:0]};
    w_pack_status = r_inexact ? 4'b1000 : 4'b0001;
    if ($signed(r_exp) >= $signed(EXP_OVF)) begin
      w_pack_data   = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_pack_status = 4'b0010;
    end else if (($signed(r_exp) <= $signed(XZERO)) && (r_mant != '0)) begin
      w_pack_data   = '0;
      w_pack_status = 4'b0100;
    end else if (r_mant == '0) begin
      w_pack_data   = '0;
      w_pack_status = 4'b0001;
    end
  end

  // State register
  always_ff @(posedge clock_100KHz or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: a fixed walk through the pipeline steps, one clock each
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (start_in) w_state_nxt = S_ALIGN;
      S_ALIGN:     w_state_nxt = S_OPERATE;
      S_OPERATE:   w_state_nxt = S_NORMALIZE;
      S_NORMALIZE: w_state_nxt = S_ROUND;
      S_ROUND:     w_state_nxt = S_PACK;
      S_PACK:      w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers advance one step per state
  always_ff @(posedge clock_100KHz or negedge reset) begin
    if (!reset) begin
      r_sign_a  <= 1'b0;
      r_sign_b  <= 1'b0;
      r_exp_a   <= '0;
      r_exp_b   <= '0;
      r_man_a   <= '0;
      r_man_b   <= '0;
      r_sign_hi <= 1'b0;
      r_sign_lo <= 1'b0;
      r_ext_hi  <= '0;
      r_ext_lo  <= '0;
      r_exp     <= '0;
      r_sum     <= '0;
      r_sign    <= 1'b0;
      r_norm    <= '0;
      r_mant    <= '0;
      r_inexact <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_in) begin
            r_sign_a <= op_A_in[W-1];
            r_sign_b <= op_B_in[W-1] ^ op_sel_in;
            r_exp_a  <= w_exp_a_in;
            r_exp_b  <= w_exp_b_in;
            r_man_a  <= w_man_a_in;
            r_man_b  <= w_man_b_in;
          end
        end
        S_ALIGN: begin
          r_sign_hi <= w_swap ? r_sign_b : r_sign_a;
          r_sign_lo <= w_swap ? r_sign_a : r_sign_b;
          r_ext_hi  <= {w_man_hi, 3'b000};
          r_ext_lo  <= w_lo_aligned;
          r_exp     <= {2'b00, w_exp_hi};
        end
        S_OPERATE: begin
          r_sum  <= w_sum;
          r_sign <= w_sign;
        end
        S_NORMALIZE: begin
          r_norm <= w_norm;
          r_exp  <= w_norm_exp;
        end
        S_ROUND: begin
          if (w_rnd[MAN_W+1]) begin
            r_mant <= {1'b1, {MAN_W{1'b0}}};
            r_exp  <= r_exp + XONE;
          end else begin
            r_mant <= w_rnd[MAN_W:0];
          end
          r_inexact <= |r_norm[2:0];
        end
        default: ;
      endcase
    end
  end

  // Handshake and result registers; result is held until the next completion
  always_ff @(posedge clock_100KHz or negedge reset) begin
    if (!reset) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_status <= '0;
      r_data   <= '0;
    end else begin
      r_done <= 1'b0;
      if ((r_state == S_IDLE) && start_in) r_busy <= 1'b1;
      if (r_state == S_PACK) begin
        r_busy   <= 1'b0;
        r_done   <= 1'b1;
        r_data   <= w_pack_data;
        r_status <= w_pack_status;
      end
    end
  end

  assign busy_out   = r_busy;
  assign done_out   = r_done;
  assign status_out = r_status;
  assign data_out   = r_data;

endmodule

// File: tb/tb_fpu_addsub_param.sv
// tb_fpu_addsub_param: directed table, hand sequences and random ops vs an
// exact-arithmetic reference for the default 1/10/21 format.
module tb_fpu_addsub_param;

  localparam int MW = 21;
  localparam int XS = 60;   // extra fraction bits used by the reference model

  logic        clock_100KHz = 1'b0;
  logic        reset;
  logic        start_in;
  logic        op_sel_in;
  logic [31:0] op_A_in;
  logic [31:0] op_B_in;
  logic        busy_out;
  logic        done_out;
  logic [3:0]  status_out;
  logic [31:0] data_out;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] prev_data;

  always #5 clock_100KHz = ~clock_100KHz;

  fpu_addsub_param dut (
    .clock_100KHz (clock_100KHz),
    .reset        (reset),
    .start_in     (start_in),
    .op_sel_in    (op_sel_in),
    .op_A_in      (op_A_in),
    .op_B_in      (op_B_in),
    .busy_out     (busy_out),
    .done_out     (done_out),
    .status_out   (status_out),
    .data_out     (data_out)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] d;
    logic [3:0]  st;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Exact reference: scale both operands to a common fixed point, add the
  // signed magnitudes exactly, then round once to nearest-even.
  function automatic logic [35:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic op);
    logic         sa, sb, s, inexact;
    int           ea, eb, emax, p, sh, e;
    logic [127:0] ma, mb, va, vb, mag, q, rem, half;
    logic [9:0]   ef;
    sa = a[31];
    sb = b[31] ^ op;
    ea = int'(a[30:21]);
    eb = int'(b[30:21]);
    ma = (ea == 0) ? 128'd0 : ((128'd1 << MW) | 128'(a[20:0]));
    mb = (eb == 0) ? 128'd0 : ((128'd1 << MW) | 128'(b[20:0]));
    emax = (ea > eb) ? ea : eb;
    // An operand far below the other only matters as a tiny nonzero residue.
    if (emax - ea > XS) va = (ma != 0) ? 128'd1 : 128'd0;
    else                va = ma << (XS - (emax - ea));
    if (emax - eb > XS) vb = (mb != 0) ? 128'd1 : 128'd0;
    else                vb = mb << (XS - (emax - eb));
    if (sa == sb) begin
      mag = va + vb; s = sa;
    end else if (va >= vb) begin
      mag = va - vb; s = sa;
    end else begin
      mag = vb - va; s = sb;
    end
    if (mag == 0) return {32'h0, 4'b0001};
    p = 0;
    for (int i = 0; i < 128; i++) if (mag[i]) p = i;
    e = emax + p - (MW + XS);
    inexact = 1'b0;
    if (p > MW) begin
      sh   = p - MW;
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = 128'd1 << (sh - 1);
      inexact = (rem != 0);
      if (rem > half || (rem == half && q[0])) q = q + 1;
    end else begin
      q = mag << (MW - p);
    end
    if (q == (128'd1 << (MW + 1))) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 1023) return {s, 10'h3FF, 21'h0, 4'b0010};
    if (e <= 0)    return {32'h0, 4'b0100};
    ef = 10'(e);
    return {s, ef, q[20:0], inexact ? 4'b1000 : 4'b0001};
  endfunction

  function automatic logic [31:0] rnd_op(input int base);
    int         e;
    logic [20:0] m;
    case ($urandom_range(0, 7))
      0:       e = 0;
      1:       e = int'($urandom_range(0, 1023));
      default: e = base + int'($urandom_range(0, 60)) - 30;
    endcase
    if (e < 0)    e = 0;
    if (e > 1023) e = 1023;
    m = 21'($urandom);
    case ($urandom_range(0, 5))
      0:       m = '0;
      1:       m = '1;
      default: ;
    endcase
    return {1'($urandom), 10'(e), m};
  endfunction

  // One operation from the current negedge: checks hold, timing and result.
  // Inputs are scrambled while busy to show they are not re-sampled.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic op,
                        input logic [31:0] exp_d, input logic [3:0] exp_st, input string tag);
    logic [11:0] obs;
    op_A_in   = a;
    op_B_in   = b;
    op_sel_in = op;
    start_in  = 1'b1;
    @(posedge clock_100KHz);
    obs = '0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock_100KHz);
      obs[2*k-2] = busy_out;
      obs[2*k-1] = done_out;
      if (k == 3) chk({tag, " hold"}, 64'(data_out), 64'(prev_data));
      if (k == 6) begin
        chk({tag, " data"}, 64'(data_out), 64'(exp_d));
        chk({tag, " status"}, 64'(status_out), 64'(exp_st));
      end
      start_in  = (k < 6) ? ($urandom_range(0, 1) == 1) : 1'b0;
      op_A_in   = $urandom;
      op_B_in   = $urandom;
      op_sel_in = 1'($urandom);
    end
    // {done,busy} per cycle: busy for cycles 1..5, done alone on cycle 6
    chk({tag, " timing"}, 64'(obs), 64'(12'h955));
    prev_data = exp_d;
  endtask

  initial begin
    logic [11:0] obs12;
    logic [35:0] r;
    logic [31:0] a, b;
    logic        op;
    int          base, ndone;

    reset     = 1'b0;
    start_in  = 1'b0;
    op_sel_in = 1'b0;
    op_A_in   = '0;
    op_B_in   = '0;
    prev_data = '0;

    vecs[0]  = '{32'h3FE00000, 32'h3FE00000, 1'b0, 32'h40000000, 4'b0001};
    vecs[1]  = '{32'h3FE00000, 32'h3FE00000, 1'b1, 32'h00000000, 4'b0001};
    vecs[2]  = '{32'h7FDFFFFF, 32'h7FDFFFFF, 1'b0, 32'h7FE00000, 4'b0010};
    vecs[3]  = '{32'h3FE00000, 32'h3D200000, 1'b0, 32'h3FE00000, 4'b1000};
    vecs[4]  = '{32'h00200001, 32'h00200000, 1'b1, 32'h00000000, 4'b0100};
    vecs[5]  = '{32'h40000000, 32'h3FE00000, 1'b1, 32'h3FE00000, 4'b0001};
    vecs[6]  = '{32'h3FE00001, 32'h3D200000, 1'b0, 32'h3FE00002, 4'b1000};
    vecs[7]  = '{32'h3FE00000, 32'h3AE00000, 1'b1, 32'h3FE00000, 4'b1000};
    vecs[8]  = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 4'b0001};
    vecs[9]  = '{32'h3FE00000, 32'h00000000, 1'b0, 32'h3FE00000, 4'b0001};
    vecs[10] = '{32'hBFE00000, 32'h3FE00000, 1'b0, 32'h00000000, 4'b0001};
    vecs[11] = '{32'h00000000, 32'h3FE00000, 1'b1, 32'hBFE00000, 4'b0001};

    repeat (2) @(negedge clock_100KHz);
    chk("reset outputs", 64'({busy_out, done_out, status_out, data_out}), 64'(0));
    reset = 1'b1;
    @(negedge clock_100KHz);
    chk("idle after reset", 64'({busy_out, done_out, status_out, data_out}), 64'(0));

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].d, vecs[i].st, $sformatf("vec%0d", i));
    end

    // start_in held high: a second operation issues on return to IDLE
    op_A_in   = 32'h40000000;
    op_B_in   = 32'h3FE00000;
    op_sel_in = 1'b1;
    start_in  = 1'b1;
    @(posedge clock_100KHz);
    obs12 = '0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock_100KHz);
      obs12[k-1] = done_out;
      if (k == 6 || k == 12) chk($sformatf("held data%0d", k), 64'(data_out), 64'(32'h3FE00000));
      if (k == 12) start_in = 1'b0;
    end
    chk("held timing", 64'(obs12), 64'(12'h820));
    prev_data = 32'h3FE00000;

    // Reset during OPERATE aborts: outputs clear at once, no done follows
    op_A_in   = 32'h3FE00000;
    op_B_in   = 32'h3D200000;
    op_sel_in = 1'b0;
    start_in  = 1'b1;
    @(posedge clock_100KHz);
    start_in = 1'b0;
    repeat (2) @(negedge clock_100KHz);
    reset = 1'b0;
    #1;
    chk("abort outputs", 64'({busy_out, done_out, status_out, data_out}), 64'(0));
    repeat (2) @(negedge clock_100KHz);
    reset = 1'b1;
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock_100KHz);
      if (done_out) ndone++;
    end
    chk("abort no done", 64'(ndone), 64'(0));
    prev_data = '0;
    run_op(vecs[0].a, vecs[0].b, vecs[0].op, vecs[0].d, vecs[0].st, "after abort");

    // Random operations against the exact reference
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 3))
        0:       base = int'($urandom_range(1, 40));
        1:       base = int'($urandom_range(980, 1023));
        default: base = int'($urandom_range(1, 1023));
      endcase
      a  = rnd_op(base);
      b  = rnd_op(base);
      op = 1'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        b  = a ^ 32'($urandom_range(0, 15));
        op = 1'b1;
      end
      r = ref_model(a, b, op);
      run_op(a, b, op, r[35:4], r[3:0], $sformatf("rand%0d a=%h b=%h op=%0d", n, a, b, op));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
